// File: rtl/crypto_in_arb.sv
// crypto_in_arb: packet-granular round-robin arbiter that feeds the single
// crypto datapath from two NetFPGA-style input streams. Each input lands in a
// small fall-through FIFO; whole packets are forwarded from one port at a time.

// Small fall-through FIFO: head word is visible on dout the cycle after it is written.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_C = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
    localparam logic [MAX_DEPTH_BITS:0] NF_C    = DEPTH_C - 1'b1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      do_wr;
    logic                      do_rd;

    assign full        = (depth == DEPTH_C);
    assign nearly_full = (depth >= NF_C);
    assign empty       = (depth == '0);
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    // Storage array; holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end
endmodule

module crypto_in_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic [CTRL_WIDTH-1:0] in0_ctrl,
    input  logic                  in0_wr,
    output logic                  in0_rdy,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic [CTRL_WIDTH-1:0] in1_ctrl,
    input  logic                  in1_wr,
    output logic                  in1_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  grant_port,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);
    localparam int FW = DATA_WIDTH + CTRL_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        HDR  = 3'b010,
        BODY = 3'b100
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_nxt;
    logic          last_grant;
    logic          eop_xfer;
    logic [FW-1:0] head0;
    logic [FW-1:0] head1;
    logic          empty0;
    logic          empty1;
    logic          nf0;
    logic          nf1;
    logic          rd0;
    logic          rd1;
    logic          head_empty;

    fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(2)) u_fifo0 (
        .clk         (clk),
        .reset       (reset),
        .din         ({in0_ctrl, in0_data}),
        .wr_en       (in0_wr),
        .rd_en       (rd0),
        .dout        (head0),
        .nearly_full (nf0),
        .empty       (empty0)
    );

    fallthrough_small_fifo #(.WIDTH(FW), .MAX_DEPTH_BITS(2)) u_fifo1 (
        .clk         (clk),
        .reset       (reset),
        .din         ({in1_ctrl, in1_data}),
        .wr_en       (in1_wr),
        .rd_en       (rd1),
        .dout        (head1),
        .nearly_full (nf1),
        .empty       (empty1)
    );

    assign in0_rdy    = !nf0;
    assign in1_rdy    = !nf1;
    assign busy       = (state != IDLE);
    assign head_empty = grant_port ? empty1 : empty0;
    assign {out_ctrl, out_data} = grant_port ? head1 : head0;
    // Reset gates the strobe so nothing leaves while the block is being cleared.
    assign out_wr     = busy && !head_empty && out_rdy && !reset;
    assign rd0        = out_wr && !grant_port;
    assign rd1        = out_wr && grant_port;

    // Next-state and grant selection; a packet ends on the first ctrl!=0 word after the body.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_port;
        eop_xfer  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    state_nxt = HDR;
                    grant_nxt = (!empty0 && !empty1) ? !last_grant : empty0;
                end
            end
            HDR: begin
                if (out_wr && (out_ctrl == '0)) state_nxt = BODY;
            end
            BODY: begin
                if (out_wr && (out_ctrl != '0)) begin
                    state_nxt = IDLE;
                    eop_xfer  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant, round-robin history and per-port completed-packet counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_port <= 1'b0;
            last_grant <= 1'b1;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            state      <= state_nxt;
            grant_port <= grant_nxt;
            if (eop_xfer) begin
                last_grant <= grant_port;
                if (grant_port) pkt_cnt1 <= pkt_cnt1 + 1'b1;
                else            pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_crypto_in_arb.sv
// Randomized bench for crypto_in_arb: packets are queued per port, the DUT is
// compared every cycle against a queue-based ownership model of the arbiter.
module tb_crypto_in_arb;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic [CW-1:0] in0_ctrl, in1_ctrl, out_ctrl;
    logic          in0_wr, in1_wr, in0_rdy, in1_rdy;
    logic          out_wr, out_rdy, grant_port, busy;
    logic [NW-1:0] pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    crypto_in_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in0_data   (in0_data),
        .in0_ctrl   (in0_ctrl),
        .in0_wr     (in0_wr),
        .in0_rdy    (in0_rdy),
        .in1_data   (in1_data),
        .in1_ctrl   (in1_ctrl),
        .in1_wr     (in1_wr),
        .in1_rdy    (in1_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .grant_port (grant_port),
        .busy       (busy),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    int checks = 0;
    int errors = 0;

    // Words not yet offered upstream: {eop, ctrl, data}
    logic [72:0]   pend [2][$];
    // Words sitting in each input buffer: {ctrl, data}
    logic [71:0]   mq   [2][$];
    bit            m_busy, m_grant, m_last, m_inbody;
    logic [NW-1:0] m_cnt [2];
    logic [NW-1:0] sent  [2];
    bit            tgl;

    task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic gen_pkt(input int p);
        int nh;
        int nb;
        nh = int'($urandom_range(2, 1));
        nb = int'($urandom_range(9, 1));
        for (int i = 0; i < nh; i++) pend[p].push_back({1'b0, 8'($urandom_range(255, 1)), rnd64()});
        for (int i = 0; i < nb; i++) pend[p].push_back({1'b0, 8'h00, rnd64()});
        pend[p].push_back({1'b1, 8'($urandom_range(255, 1)), rnd64()});
    endtask

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            mq[p].delete();
            pend[p].delete();
            m_cnt[p] = '0;
            sent[p]  = '0;
        end
        m_busy   = 1'b0;
        m_grant  = 1'b0;
        m_last   = 1'b1;
        m_inbody = 1'b0;
    endtask

    // One clock: drive at negedge, compare 1ns later, then advance the model to the next edge.
    // rdy_mode: 0 = always ready, 1 = random, 2 = toggle every cycle.
    task automatic cycle(input bit rst, input int rdy_mode, input int wr_pct, input bit gen);
        logic [72:0] w [2];
        bit          wr [2];
        bit          exp_wr, ne0, ne1;
        logic [71:0] head;
        @(negedge clk);
        reset = rst;
        for (int p = 0; p < 2; p++) begin
            wr[p] = 1'b0;
            w[p]  = '0;
            if (!rst && gen && pend[p].size() == 0 && int'($urandom_range(99)) < wr_pct) gen_pkt(p);
            if (!rst && pend[p].size() > 0 && mq[p].size() < 3 && int'($urandom_range(99)) < wr_pct) begin
                wr[p] = 1'b1;
                w[p]  = pend[p][0];
            end
        end
        in0_wr = wr[0]; in0_ctrl = w[0][71:64]; in0_data = w[0][63:0];
        in1_wr = wr[1]; in1_ctrl = w[1][71:64]; in1_data = w[1][63:0];
        tgl = !tgl;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = 1'($urandom_range(1));
            default: out_rdy = tgl;
        endcase
        #1;
        ne0 = mq[0].size() > 0;
        ne1 = mq[1].size() > 0;
        exp_wr = !rst && m_busy && mq[m_grant].size() > 0 && out_rdy;
        check_eq("in0_rdy", 72'(in0_rdy), 72'(mq[0].size() < 3));
        check_eq("in1_rdy", 72'(in1_rdy), 72'(mq[1].size() < 3));
        check_eq("busy", 72'(busy), 72'(m_busy));
        check_eq("out_wr", 72'(out_wr), 72'(exp_wr));
        check_eq("pkt_cnt0", 72'(pkt_cnt0), 72'(m_cnt[0]));
        check_eq("pkt_cnt1", 72'(pkt_cnt1), 72'(m_cnt[1]));
        if (m_busy) check_eq("grant_port", 72'(grant_port), 72'(m_grant));
        if (m_busy && mq[m_grant].size() > 0) check_eq("out_word", {out_ctrl, out_data}, mq[m_grant][0]);
        if (rst) begin
            model_clear();
        end else begin
            if (exp_wr) begin
                head = mq[m_grant].pop_front();
                if (!m_inbody) begin
                    if (head[71:64] == '0) m_inbody = 1'b1;
                end else if (head[71:64] != '0) begin
                    m_busy = 1'b0;
                    m_last = m_grant;
                    m_cnt[m_grant] = m_cnt[m_grant] + 1'b1;
                end
            end else if (!m_busy && (ne0 || ne1)) begin
                // Port other than the last winner goes first when both have data.
                m_grant  = (ne0 && ne1) ? !m_last : ne1;
                m_busy   = 1'b1;
                m_inbody = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (wr[p]) begin
                    mq[p].push_back(w[p][71:0]);
                    pend[p].delete(0);
                    if (w[p][72]) sent[p] = sent[p] + 1'b1;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in0_wr = 1'b0; in0_ctrl = '0; in0_data = '0;
        in1_wr = 1'b0; in1_ctrl = '0; in1_data = '0;
        out_rdy = 1'b0;
        tgl = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        cycle(1'b1, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);

        repeat (1200) cycle(1'b0, 0, 75, 1'b1);
        repeat (1200) cycle(1'b0, 1, 85, 1'b1);
        repeat (600)  cycle(1'b0, 2, 95, 1'b1);

        // Hit the arbiter with reset while a packet body is flowing.
        for (int i = 0; i < 400 && !(m_busy && m_inbody); i++) cycle(1'b0, 1, 80, 1'b1);
        cycle(1'b1, 1, 0, 1'b0);
        cycle(1'b0, 1, 0, 1'b0);
        repeat (600) cycle(1'b0, 1, 60, 1'b1);

        // Let everything already started drain out.
        repeat (400) cycle(1'b0, 0, 100, 1'b0);
        #1;
        check_eq("final_busy", 72'(busy), 72'(0));
        check_eq("final_in0_rdy", 72'(in0_rdy), 72'(1));
        check_eq("final_in1_rdy", 72'(in1_rdy), 72'(1));
        check_eq("final_cnt0_vs_sent", 72'(pkt_cnt0), 72'(sent[0]));
        check_eq("final_cnt1_vs_sent", 72'(pkt_cnt1), 72'(sent[1]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
